fetch_pc_stage: RTL and testbench
=================================

Name: fetch_pc_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the program counter and computes PC+4. It selects the next PC from the sequential path or from redirect targets produced downstream: branch target adder, jump target, and jr register value. It also owns the IF/ID pipeline register, with stall and flush control from the hazard unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned)
CNT_W, 16, width of the saturating redirect counter

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Stall  input  1  hazard unit: hold PC and IF/ID contents
Flush  input  1  hazard unit: load bubble into IF/ID
BranchTaken  input  1  branch resolved taken in ID
BranchTarget  input  32  branch target address (PC+4 + imm<<2)
JumpTaken  input  1  j/jal decoded in ID
JumpTarget  input  32  jump target address
JrTaken  input  1  jr decoded in ID
JrTarget  input  32  register value for jr
InstrIn  input  32  instruction-memory read data for InstrAddr (combinational)
InstrAddr  output  32  current PC driven to instruction memory
IFID_Instr  output  32  registered instruction
IFID_PCPlus4  output  32  registered PC+4 of that instruction
IFID_Valid  output  1  IF/ID holds a real instruction (0 = bubble)
AlignErr  output  1  one-cycle pulse: selected redirect target had bits[1:0] != 0
RedirectCount  output  CNT_W  saturating count of accepted redirects

Behaviour:
- One clock (Clk). Reset is synchronous and active-high (Reset). All registers update on rising Clk only.
- Reset (sampled high at an edge):
  - PC <= RESET_PC.
  - IFID_Instr <= 0, IFID_PCPlus4 <= 0, IFID_Valid <= 0.
  - AlignErr <= 0, RedirectCount <= 0.
  - Reset overrides every other input.
- InstrAddr = PC (combinational). PCPlus4 = PC + 4, 32-bit modulo: 32'hFFFF_FFFC wraps to 0.
- Redirect priority: JrTaken > JumpTaken > BranchTaken.
  - Redirect = OR of the three.
  - Target = target of the highest-priority asserted input, with bits[1:0] forced to 0.
- AlignErr <= Redirect AND (raw selected target[1:0] != 0). It is registered and high for one cycle only.
- Next PC:
  - Redirect: PC <= Target, regardless of Stall (the redirect wins over the stall).
  - Else if Stall: PC holds.
  - Else: PC <= PCPlus4.
- IF/ID register:
  - Redirect or Flush: IFID_Valid <= 0, IFID_Instr <= 0 (nop), IFID_PCPlus4 <= 0. Flush overrides Stall.
  - Else if Stall: all IF/ID fields hold.
  - Else: IFID_Instr <= InstrIn, IFID_PCPlus4 <= PCPlus4, IFID_Valid <= 1.
- Latency:
  - A redirect asserted in cycle N is fetched at the new PC in cycle N+1.
  - That instruction appears in IF/ID in cycle N+2.
  - The instruction fetched in cycle N is squashed (no delay slot).
- RedirectCount increments by 1 on each cycle with Redirect=1 and Reset=0. It saturates at all-ones.
- Reset mid-operation: any pending redirect, stall or flush in the same cycle is discarded. The cycle after reset fetches at RESET_PC with IFID_Valid=0.
- Simultaneous Stall+Flush with no redirect: PC holds and IF/ID becomes a bubble.

Test Plan:
- Reset then 3 free-running cycles, InstrIn=32'h2008_0005 -> InstrAddr 0,4,8,C; IFID_Valid 0 then 1; IFID_PCPlus4=4 after the first fetch edge.
- Stall=1 for 2 cycles at PC=8 -> InstrAddr stays 8; IFID_Instr/PCPlus4 unchanged; resumes at C on release.
- BranchTaken=1, BranchTarget=32'h40, with Stall=1 in the same cycle -> next InstrAddr=40; IFID_Valid=0; RedirectCount=1.
- JrTaken=1 (JrTarget=32'h100) with JumpTaken=1 (JumpTarget=32'h200) and BranchTaken=1 (BranchTarget=32'h300) -> InstrAddr=100.
- JumpTaken=1, JumpTarget=32'h0000_0046 -> InstrAddr=44; AlignErr=1 for exactly one cycle.
- PC=32'hFFFF_FFFC, no stall -> next InstrAddr=0. Force 2^16+3 redirects -> RedirectCount=16'hFFFF. Reset asserted together with BranchTaken -> InstrAddr=RESET_PC and counter=0.

Source files
------------

// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage: program counter, redirect selection and IF/ID pipeline register
module fetch_pc_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             BranchTaken,
    input  logic [31:0]      BranchTarget,
    input  logic             JumpTaken,
    input  logic [31:0]      JumpTarget,
    input  logic             JrTaken,
    input  logic [31:0]      JrTarget,
    input  logic [31:0]      InstrIn,
    output logic [31:0]      InstrAddr,
    output logic [31:0]      IFID_Instr,
    output logic [31:0]      IFID_PCPlus4,
    output logic             IFID_Valid,
    output logic             AlignErr,
    output logic [CNT_W-1:0] RedirectCount
);
    logic [31:0]      pc_q, pc_d, pc_plus4, tgt_raw, target;
    logic [31:0]      instr_q, instr_d, p4_q, p4_d;
    logic             valid_q, valid_d, align_q, align_d, redirect, bubble;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        redirect = JrTaken | JumpTaken | BranchTaken;
        tgt_raw  = JrTaken ? JrTarget : JumpTaken ? JumpTarget : BranchTarget;
        target   = {tgt_raw[31:2], 2'b00};
        pc_plus4 = pc_q + 32'd4;
        // a redirect squashes the wrong-path fetch and beats any stall
        bubble   = redirect | Flush;
        pc_d     = redirect ? target : Stall ? pc_q : pc_plus4;
        instr_d  = bubble ? 32'd0 : Stall ? instr_q : InstrIn;
        p4_d     = bubble ? 32'd0 : Stall ? p4_q : pc_plus4;
        valid_d  = bubble ? 1'b0 : Stall ? valid_q : 1'b1;
        align_d  = redirect & (|tgt_raw[1:0]);
        cnt_d    = (redirect && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            p4_q    <= '0;
            valid_q <= 1'b0;
            align_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            p4_q    <= p4_d;
            valid_q <= valid_d;
            align_q <= align_d;
            cnt_q   <= cnt_d;
        end
    end

    assign InstrAddr     = pc_q;
    assign IFID_Instr    = instr_q;
    assign IFID_PCPlus4  = p4_q;
    assign IFID_Valid    = valid_q;
    assign AlignErr      = align_q;
    assign RedirectCount = cnt_q;
endmodule

// File: tb/tb_fetch_pc_stage.sv
// tb_fetch_pc_stage: directed and randomized checks of fetch_pc_stage against a behavioural model
module tb_fetch_pc_stage;
    logic        Clk = 1'b0, Reset, Stall, Flush;
    logic        BranchTaken, JumpTaken, JrTaken;
    logic [31:0] BranchTarget, JumpTarget, JrTarget, InstrIn;
    logic [31:0] InstrAddr, IFID_Instr, IFID_PCPlus4;
    logic        IFID_Valid, AlignErr;
    logic [15:0] RedirectCount;

    int vectors = 0, miscompares = 0;

    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_valid, m_align;
    int          m_cnt;

    fetch_pc_stage dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .JumpTaken(JumpTaken), .JumpTarget(JumpTarget),
        .JrTaken(JrTaken), .JrTarget(JrTarget), .InstrIn(InstrIn),
        .InstrAddr(InstrAddr), .IFID_Instr(IFID_Instr), .IFID_PCPlus4(IFID_PCPlus4),
        .IFID_Valid(IFID_Valid), .AlignErr(AlignErr), .RedirectCount(RedirectCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        Reset = 0; Stall = 0; Flush = 0;
        BranchTaken = 0; JumpTaken = 0; JrTaken = 0;
    endtask

    // one clock: advance the model from the architectural rules, then compare every output
    task automatic tick();
        logic        rd;
        logic [31:0] raw, nxt4;
        @(posedge Clk);
        rd   = JrTaken | JumpTaken | BranchTaken;
        raw  = JrTaken ? JrTarget : (JumpTaken ? JumpTarget : BranchTarget);
        nxt4 = m_pc + 32'd4;
        if (Reset) begin
            m_pc = 32'h0; m_instr = 0; m_p4 = 0; m_valid = 0; m_align = 0; m_cnt = 0;
        end else begin
            m_align = rd && (raw % 4 != 0);
            if (rd) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            if (rd || Flush) begin
                m_instr = 0; m_p4 = 0; m_valid = 0;
            end else if (!Stall) begin
                m_instr = InstrIn; m_p4 = nxt4; m_valid = 1;
            end
            m_pc = rd ? raw - (raw % 4) : (Stall ? m_pc : nxt4);
        end
        #1;
        chk("pc", InstrAddr, m_pc);
        chk("ifid_instr", IFID_Instr, m_instr);
        chk("ifid_pc4", IFID_PCPlus4, m_p4);
        chk("ifid_valid", {31'd0, IFID_Valid}, {31'd0, m_valid});
        chk("align_err", {31'd0, AlignErr}, {31'd0, m_align});
        chk("redir_cnt", {16'd0, RedirectCount}, m_cnt);
    endtask

    initial begin
        m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0; m_align = 0; m_cnt = 0;
        idle();
        BranchTarget = 0; JumpTarget = 0; JrTarget = 0;
        InstrIn = 32'h2008_0005;
        #2;
        Reset = 1; tick(); tick();
        Reset = 0;
        chk("rst_pc", InstrAddr, 32'h0);
        chk("rst_valid", {31'd0, IFID_Valid}, 32'd0);
        tick();
        chk("run_pc4", InstrAddr, 32'h4);
        chk("run_valid", {31'd0, IFID_Valid}, 32'd1);
        chk("run_ifid_pc4", IFID_PCPlus4, 32'h4);
        tick();
        chk("run_pc8", InstrAddr, 32'h8);
        Stall = 1; tick(); tick();
        chk("stall_pc", InstrAddr, 32'h8);
        chk("stall_ifid_pc4", IFID_PCPlus4, 32'h8);
        Stall = 0; tick();
        chk("resume_pc", InstrAddr, 32'hC);
        BranchTaken = 1; BranchTarget = 32'h40; Stall = 1; tick();
        idle();
        chk("br_stall_pc", InstrAddr, 32'h40);
        chk("br_stall_valid", {31'd0, IFID_Valid}, 32'd0);
        chk("br_stall_cnt", {16'd0, RedirectCount}, 32'd1);
        JrTaken = 1; JrTarget = 32'h100; JumpTaken = 1; JumpTarget = 32'h200;
        BranchTaken = 1; BranchTarget = 32'h300; tick();
        idle();
        chk("prio_pc", InstrAddr, 32'h100);
        JumpTaken = 1; JumpTarget = 32'h46; tick();
        idle();
        chk("align_pc", InstrAddr, 32'h44);
        chk("align_hi", {31'd0, AlignErr}, 32'd1);
        tick();
        chk("align_lo", {31'd0, AlignErr}, 32'd0);
        JrTaken = 1; JrTarget = 32'hFFFF_FFFC; tick();
        idle(); tick();
        chk("wrap_pc", InstrAddr, 32'h0);
        chk("wrap_ifid_pc4", IFID_PCPlus4, 32'h0);
        tick();
        Stall = 1; Flush = 1; tick();
        idle();
        chk("stall_flush_pc", InstrAddr, 32'h4);
        chk("stall_flush_valid", {31'd0, IFID_Valid}, 32'd0);

        for (int i = 0; i < 2000; i++) begin
            Reset        = ($urandom_range(99) < 2);
            Stall        = ($urandom_range(99) < 25);
            Flush        = ($urandom_range(99) < 10);
            BranchTaken  = ($urandom_range(99) < 12);
            JumpTaken    = ($urandom_range(99) < 8);
            JrTaken      = ($urandom_range(99) < 6);
            BranchTarget = $urandom;
            JumpTarget   = $urandom_range(3) == 0 ? $urandom : {$urandom_range(32'h3FFF_FFFF), 2'b00};
            JrTarget     = $urandom;
            InstrIn      = $urandom;
            tick();
        end

        idle(); Reset = 1; tick();
        Reset = 0; BranchTaken = 1;
        for (int i = 0; i < 65539; i++) begin
            BranchTarget = $urandom;
            tick();
        end
        idle();
        chk("sat_cnt", {16'd0, RedirectCount}, 32'h0000_FFFF);
        Reset = 1; BranchTaken = 1; BranchTarget = 32'h40; tick();
        idle();
        chk("rst_br_pc", InstrAddr, 32'h0);
        chk("rst_br_cnt", {16'd0, RedirectCount}, 32'd0);
        tick();
        chk("post_rst_pc", InstrAddr, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
